mc_bus_vex: RTL and testbench



---
 rtl/mc_bus_vex_pkg.sv | 25 ++
 rtl/mc_bus_vex_decode.sv | 24 ++
 rtl/mc_bus_vex.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mc_bus_vex.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_bus_vex_pkg.sv
// rtl/mc_bus_vex_pkg.sv - shared constants for the VexRiscv bus bridge
// Purpose: region codes, arbiter state codes and bus widths used by
//          mc_bus_vex and its address decoder.
// Ports:   none (package).
package mc_bus_vex_pkg;

  localparam int DATA_W   = 32;
  localparam int WB_AW    = 22;
  localparam int RAM_AW   = 28;

  // Region code is simply byte address bits [31:30].
  localparam logic [1:0] REG_RAM    = 2'b00;
  localparam logic [1:0] REG_CACHE  = 2'b01;
  localparam logic [1:0] REG_PERIPH = 2'b10;
  localparam logic [1:0] REG_NONE   = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_D_RAM   = 3'd1;
  localparam logic [2:0] ST_D_CACHE = 3'd2;
  localparam logic [2:0] ST_D_WB    = 3'd3;
  localparam logic [2:0] ST_D_RESP  = 3'd4;
  localparam logic [2:0] ST_I_RAM   = 3'd5;
  localparam logic [2:0] ST_I_CACHE = 3'd6;

endpackage

// File: rtl/mc_bus_vex_decode.sv
// rtl/mc_bus_vex_decode.sv - combinational byte address to region/slave decode
// Purpose: split a 32-bit byte address into region code, peripheral slave
//          index and the word addresses used by each downstream port.
// Ports:   addr (in, byte address); region, slave, mem_word (BRAM/cache
//          word address), wb_word (peripheral word address) out.
module mc_bus_vex_decode
  import mc_bus_vex_pkg::*;
(
  input  logic [31:0]       addr,
  output logic [1:0]        region,
  output logic [3:0]        slave,
  output logic [RAM_AW-1:0] mem_word,
  output logic [WB_AW-1:0]  wb_word
);

  logic unused_byte_lane;

  assign region   = addr[31:30];
  assign slave    = addr[27:24];
  assign mem_word = addr[29:2];
  assign wb_word  = addr[23:2];
  assign unused_byte_lane = ^addr[1:0];

endmodule

// File: rtl/mc_bus_vex.sv
// rtl/mc_bus_vex.sv - VexRiscv iBus/dBus bridge to BRAM, cache and peripherals
// Purpose: arbitrates the AXI4 read-only instruction bus and the Wishbone
//          data bus (dBus wins ties, bursts never preempted) and routes each
//          access by address region.
// Ports:   clk, rst; i_axi_ar_* / i_axi_r_* (iBus); d_wb_* (dBus);
//          wb_* (one-hot peripheral bus); ram_* (boot BRAM, 1-cycle read);
//          req_* / resp_* (memory cache request port).
module mc_bus_vex
  import mc_bus_vex_pkg::*;
#(
  parameter int WB_N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_axi_ar_valid,
  output logic                   i_axi_ar_ready,
  input  logic [31:0]            i_axi_ar_payload_addr,
  input  logic [7:0]             i_axi_ar_payload_len,
  input  logic [1:0]             i_axi_ar_payload_burst,
  input  logic [3:0]             i_axi_ar_payload_cache,
  input  logic [2:0]             i_axi_ar_payload_prot,
  output logic                   i_axi_r_valid,
  input  logic                   i_axi_r_ready,
  output logic [31:0]            i_axi_r_payload_data,
  output logic [1:0]             i_axi_r_payload_resp,
  output logic                   i_axi_r_payload_last,
  input  logic                   d_wb_cyc,
  input  logic                   d_wb_stb,
  input  logic                   d_wb_we,
  input  logic [29:0]            d_wb_adr,
  input  logic [31:0]            d_wb_dat_mosi,
  input  logic [3:0]             d_wb_sel,
  input  logic [1:0]             d_wb_bte,
  input  logic [2:0]             d_wb_cti,
  output logic                   d_wb_ack,
  output logic                   d_wb_err,
  output logic [31:0]            d_wb_dat_miso,
  output logic [WB_AW-1:0]       wb_addr,
  output logic [31:0]            wb_wdata,
  output logic [3:0]             wb_wmsk,
  output logic                   wb_we,
  output logic [WB_N-1:0]        wb_cyc,
  input  logic [WB_N-1:0]        wb_ack,
  input  logic [32*WB_N-1:0]     wb_rdata,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [31:0]            ram_wdata,
  output logic [3:0]             ram_wmsk,
  output logic                   ram_we,
  input  logic [31:0]            ram_rdata,
  output logic [RAM_AW-1:0]      req_addr_pre,
  output logic                   req_valid,
  output logic                   req_write,
  output logic [31:0]            req_wdata,
  output logic [3:0]             req_wmsk,
  input  logic                   resp_ack,
  input  logic                   resp_nak,
  input  logic [31:0]            resp_rdata
);

  logic [2:0]        state;
  logic [31:0]       rdata_q;
  logic              src_ram;   // current read data comes straight from BRAM
  logic              rv_q;      // iBus beat valid this cycle
  logic              rl_q;      // that beat is the last one
  logic              issuing;   // BRAM burst still presenting addresses
  logic [7:0]        cnt;
  logic [7:0]        len_q;

  logic [1:0]        d_region, i_region;
  logic [3:0]        d_slave, i_slave;
  logic [RAM_AW-1:0] d_word, i_word;
  logic [WB_AW-1:0]  d_wb_word, i_wb_word;

  logic              d_req;
  logic [WB_N-1:0]   d_onehot;
  logic [31:0]       sel_rdata;
  logic              sel_ack;
  logic              unused_in;

  mc_bus_vex_decode u_dec_d (
    .addr     ({d_wb_adr, 2'b00}),
    .region   (d_region),
    .slave    (d_slave),
    .mem_word (d_word),
    .wb_word  (d_wb_word)
  );

  mc_bus_vex_decode u_dec_i (
    .addr     (i_axi_ar_payload_addr),
    .region   (i_region),
    .slave    (i_slave),
    .mem_word (i_word),
    .wb_word  (i_wb_word)
  );

  assign unused_in = ^{i_axi_ar_payload_burst, i_axi_ar_payload_cache,
                       i_axi_ar_payload_prot, i_axi_r_ready, d_wb_bte,
                       d_wb_cti, i_slave, i_wb_word, resp_nak};

  assign d_req = d_wb_cyc & d_wb_stb;

  // wb_cyc is one-hot, so OR-ing the selected lanes picks the active slave.
  always_comb begin
    d_onehot  = '0;
    sel_rdata = '0;
    sel_ack   = 1'b0;
    for (int i = 0; i < WB_N; i++) begin
      d_onehot[i] = (d_slave == 4'(i));
      if (wb_cyc[i]) begin
        sel_rdata = sel_rdata | wb_rdata[32*i +: 32];
        sel_ack   = sel_ack | wb_ack[i];
      end
    end
  end

  assign i_axi_ar_ready       = (state == ST_IDLE) && !d_req && i_axi_ar_valid;
  assign i_axi_r_valid        = rv_q;
  assign i_axi_r_payload_last = rv_q & rl_q;
  assign i_axi_r_payload_data = rv_q ? (src_ram ? ram_rdata : rdata_q) : 32'd0;
  assign i_axi_r_payload_resp = 2'b00;

  assign d_wb_ack      = (state == ST_D_RESP);
  assign d_wb_err      = 1'b0;
  assign d_wb_dat_miso = (state == ST_D_RESP) ? (src_ram ? ram_rdata : rdata_q) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rdata_q      <= '0;
      src_ram      <= 1'b0;
      rv_q         <= 1'b0;
      rl_q         <= 1'b0;
      issuing      <= 1'b0;
      cnt          <= '0;
      len_q        <= '0;
      wb_addr      <= '0;
      wb_wdata     <= '0;
      wb_wmsk      <= '0;
      wb_we        <= 1'b0;
      wb_cyc       <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_wmsk     <= '0;
      ram_we       <= 1'b0;
      req_addr_pre <= '0;
      req_valid    <= 1'b0;
      req_write    <= 1'b0;
      req_wdata    <= '0;
      req_wmsk     <= '0;
    end else begin
      ram_we <= 1'b0;
      rv_q   <= 1'b0;
      rl_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (d_req) begin
            src_ram <= 1'b0;
            rdata_q <= '0;
            case (d_region)
              REG_RAM: begin
                ram_addr  <= d_word;
                ram_wdata <= d_wb_dat_mosi;
                ram_wmsk  <= d_wb_sel;
                if (d_wb_we) begin
                  ram_we <= 1'b1;
                  state  <= ST_D_RESP;
                end else begin
                  src_ram <= 1'b1;
                  state   <= ST_D_RAM;
                end
              end
              REG_CACHE: begin
                req_addr_pre <= d_word;
                req_write    <= d_wb_we;
                req_wdata    <= d_wb_dat_mosi;
                req_wmsk     <= d_wb_sel;
                state        <= ST_D_CACHE;
              end
              REG_PERIPH: begin
                if (int'(d_slave) < WB_N) begin
                  wb_cyc   <= d_onehot;
                  wb_addr  <= d_wb_word;
                  wb_wdata <= d_wb_dat_mosi;
                  wb_wmsk  <= d_wb_sel;
                  wb_we    <= d_wb_we;
                  state    <= ST_D_WB;
                end else begin
                  state <= ST_D_RESP;
                end
              end
              default: state <= ST_D_RESP;
            endcase
          end else if (i_axi_ar_valid) begin
            len_q   <= i_axi_ar_payload_len;
            cnt     <= '0;
            rdata_q <= '0;
            src_ram <= 1'b0;
            issuing <= 1'b1;
            case (i_region)
              REG_RAM: begin
                ram_addr <= i_word;
                src_ram  <= 1'b1;
                state    <= ST_I_RAM;
              end
              REG_CACHE: begin
                req_addr_pre <= i_word;
                req_write    <= 1'b0;
                state        <= ST_I_CACHE;
              end
              // Peripheral/unmapped fetches reuse the BRAM beat timing with zero data.
              default: state <= ST_I_RAM;
            endcase
          end
        end
        ST_D_RAM: state <= ST_D_RESP;
        ST_D_CACHE: begin
          // First cycle only presents req_addr_pre; nak keeps req_valid high.
          if (!req_valid) begin
            req_valid <= 1'b1;
          end else if (resp_ack) begin
            req_valid <= 1'b0;
            rdata_q   <= resp_rdata;
            state     <= ST_D_RESP;
          end
        end
        ST_D_WB: begin
          if (sel_ack) begin
            rdata_q <= sel_rdata;
            wb_cyc  <= '0;
            wb_we   <= 1'b0;
            state   <= ST_D_RESP;
          end
        end
        ST_D_RESP: state <= ST_IDLE;
        ST_I_RAM: begin
          // Address presented this cycle produces a beat next cycle.
          if (issuing) begin
            rv_q <= 1'b1;
            rl_q <= (cnt == len_q);
            if (cnt == len_q) begin
              issuing <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
              if (src_ram) ram_addr <= ram_addr + 28'd1;
            end
          end
          if (rv_q && rl_q) state <= ST_IDLE;
        end
        ST_I_CACHE: begin
          if (!req_valid) begin
            req_valid <= 1'b1;
          end else if (resp_ack) begin
            req_valid <= 1'b0;
            rdata_q   <= resp_rdata;
            rv_q      <= 1'b1;
            rl_q      <= (cnt == len_q);
            if (cnt == len_q) begin
              state <= ST_IDLE;
            end else begin
              cnt          <= cnt + 8'd1;
              req_addr_pre <= req_addr_pre + 28'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_bus_vex.sv
// tb/tb_mc_bus_vex.sv - directed self-checking bench for mc_bus_vex
module tb_mc_bus_vex;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_axi_ar_valid;
  logic         i_axi_ar_ready;
  logic [31:0]  i_axi_ar_payload_addr;
  logic [7:0]   i_axi_ar_payload_len;
  logic [1:0]   i_axi_ar_payload_burst;
  logic [3:0]   i_axi_ar_payload_cache;
  logic [2:0]   i_axi_ar_payload_prot;
  logic         i_axi_r_valid;
  logic         i_axi_r_ready;
  logic [31:0]  i_axi_r_payload_data;
  logic [1:0]   i_axi_r_payload_resp;
  logic         i_axi_r_payload_last;
  logic         d_wb_cyc, d_wb_stb, d_wb_we;
  logic [29:0]  d_wb_adr;
  logic [31:0]  d_wb_dat_mosi;
  logic [3:0]   d_wb_sel;
  logic [1:0]   d_wb_bte;
  logic [2:0]   d_wb_cti;
  logic         d_wb_ack, d_wb_err;
  logic [31:0]  d_wb_dat_miso;
  logic [21:0]  wb_addr;
  logic [31:0]  wb_wdata;
  logic [3:0]   wb_wmsk;
  logic         wb_we;
  logic [3:0]   wb_cyc;
  logic [3:0]   wb_ack;
  logic [127:0] wb_rdata;
  logic [27:0]  ram_addr;
  logic [31:0]  ram_wdata;
  logic [3:0]   ram_wmsk;
  logic         ram_we;
  logic [31:0]  ram_rdata;
  logic [27:0]  req_addr_pre;
  logic         req_valid, req_write;
  logic [31:0]  req_wdata;
  logic [3:0]   req_wmsk;
  logic         resp_ack, resp_nak;
  logic [31:0]  resp_rdata;

  logic [31:0]  mem [16];
  int           pass_cnt = 0;
  int           total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= mem[ram_addr[3:0]];

  mc_bus_vex #(.WB_N(4)) dut (
    .clk(clk), .rst(rst),
    .i_axi_ar_valid(i_axi_ar_valid), .i_axi_ar_ready(i_axi_ar_ready),
    .i_axi_ar_payload_addr(i_axi_ar_payload_addr), .i_axi_ar_payload_len(i_axi_ar_payload_len),
    .i_axi_ar_payload_burst(i_axi_ar_payload_burst), .i_axi_ar_payload_cache(i_axi_ar_payload_cache),
    .i_axi_ar_payload_prot(i_axi_ar_payload_prot),
    .i_axi_r_valid(i_axi_r_valid), .i_axi_r_ready(i_axi_r_ready),
    .i_axi_r_payload_data(i_axi_r_payload_data), .i_axi_r_payload_resp(i_axi_r_payload_resp),
    .i_axi_r_payload_last(i_axi_r_payload_last),
    .d_wb_cyc(d_wb_cyc), .d_wb_stb(d_wb_stb), .d_wb_we(d_wb_we), .d_wb_adr(d_wb_adr),
    .d_wb_dat_mosi(d_wb_dat_mosi), .d_wb_sel(d_wb_sel), .d_wb_bte(d_wb_bte), .d_wb_cti(d_wb_cti),
    .d_wb_ack(d_wb_ack), .d_wb_err(d_wb_err), .d_wb_dat_miso(d_wb_dat_miso),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack), .wb_rdata(wb_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmsk(ram_wmsk), .ram_we(ram_we),
    .ram_rdata(ram_rdata),
    .req_addr_pre(req_addr_pre), .req_valid(req_valid), .req_write(req_write),
    .req_wdata(req_wdata), .req_wmsk(req_wmsk),
    .resp_ack(resp_ack), .resp_nak(resp_nak), .resp_rdata(resp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tk;
    @(posedge clk);
    #1;
  endtask

  task automatic dreq(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
    d_wb_cyc = 1'b1; d_wb_stb = 1'b1; d_wb_we = we;
    d_wb_adr = adr; d_wb_dat_mosi = dat; d_wb_sel = sel;
  endtask

  task automatic ddrop;
    d_wb_cyc = 1'b0; d_wb_stb = 1'b0; d_wb_we = 1'b0;
  endtask

  function automatic logic [31:0] mem_val(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'hA5A5_0000 + 32'(i));
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = mem_val(i);
    rst = 1'b1;
    i_axi_ar_valid = 0; i_axi_ar_payload_addr = 0; i_axi_ar_payload_len = 0;
    i_axi_ar_payload_burst = 2'b01; i_axi_ar_payload_cache = 0; i_axi_ar_payload_prot = 0;
    i_axi_r_ready = 1'b1;
    d_wb_cyc = 0; d_wb_stb = 0; d_wb_we = 0; d_wb_adr = 0; d_wb_dat_mosi = 0;
    d_wb_sel = 0; d_wb_bte = 0; d_wb_cti = 0;
    wb_ack = 0;
    wb_rdata = {32'h4444_4444, 32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111};
    resp_ack = 0; resp_nak = 0; resp_rdata = 0;

    // Reset values
    #12;
    chk("rst_ack", d_wb_ack, 0);
    chk("rst_rvalid", i_axi_r_valid, 0);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_miso", d_wb_dat_miso, 0);
    rst = 1'b0;
    tk;

    // dBus BRAM read 0x10
    dreq(0, 30'h4, 0, 4'hF);
    tk;
    chk("bram_rd_addr", ram_addr, 4);
    chk("bram_rd_ack_early", d_wb_ack, 0);
    tk;
    chk("bram_rd_ack", d_wb_ack, 1);
    chk("bram_rd_data", d_wb_dat_miso, 32'hDEAD_BEEF);
    ddrop;
    tk;
    chk("bram_rd_ack_pulse", d_wb_ack, 0);

    // dBus peripheral write 0x8200_0004
    dreq(1, 30'h2080_0001, 32'h55, 4'b0001);
    tk;
    chk("wb_wr_cyc", wb_cyc, 4'b0100);
    chk("wb_wr_addr", wb_addr, 1);
    chk("wb_wr_wmsk", wb_wmsk, 4'b0001);
    chk("wb_wr_we", wb_we, 1);
    chk("wb_wr_wdata", wb_wdata, 32'h55);
    tk;
    tk;
    chk("wb_wr_cyc_held", wb_cyc, 4'b0100);
    chk("wb_wr_no_ack", d_wb_ack, 0);
    wb_ack = 4'b0100;
    tk;
    wb_ack = 0;
    chk("wb_wr_ack", d_wb_ack, 1);
    chk("wb_wr_cyc_drop", wb_cyc, 0);
    ddrop;
    tk;
    chk("wb_wr_ack_pulse", d_wb_ack, 0);

    // dBus peripheral read 0x8100_0008 from slave 1
    dreq(0, 30'h2040_0002, 0, 4'hF);
    tk;
    chk("wb_rd_cyc", wb_cyc, 4'b0010);
    chk("wb_rd_addr", wb_addr, 2);
    wb_ack = 4'b0010;
    tk;
    wb_ack = 0;
    chk("wb_rd_ack", d_wb_ack, 1);
    chk("wb_rd_data", d_wb_dat_miso, 32'hCAFE_F00D);
    ddrop;
    tk;

    // dBus cache read 0x4000_0100, two naks then ack
    dreq(0, 30'h1000_0040, 0, 4'hF);
    tk;
    chk("c_addr_pre", req_addr_pre, 28'h40);
    chk("c_valid_late", req_valid, 0);
    tk;
    chk("c_valid1", req_valid, 1);
    resp_nak = 1;
    tk;
    chk("c_valid2", req_valid, 1);
    tk;
    chk("c_valid3", req_valid, 1);
    chk("c_addr_stable", req_addr_pre, 28'h40);
    resp_nak = 0; resp_ack = 1; resp_rdata = 32'h1234_5678;
    tk;
    resp_ack = 0; resp_rdata = 0;
    chk("c_ack", d_wb_ack, 1);
    chk("c_data", d_wb_dat_miso, 32'h1234_5678);
    chk("c_valid_drop", req_valid, 0);
    ddrop;
    tk;

    // iBus burst addr 0 len 7
    i_axi_ar_valid = 1; i_axi_ar_payload_addr = 32'h0; i_axi_ar_payload_len = 8'd7;
    #1;
    chk("ib_ar_ready", i_axi_ar_ready, 1);
    tk;
    i_axi_ar_valid = 0;
    #1;
    chk("ib_ar_pulse", i_axi_ar_ready, 0);
    chk("ib_no_beat", i_axi_r_valid, 0);
    for (int b = 0; b < 8; b++) begin
      tk;
      chk("ib_valid", i_axi_r_valid, 1);
      chk("ib_data", i_axi_r_payload_data, mem_val(b));
      chk("ib_last", i_axi_r_payload_last, (b == 7));
    end
    tk;
    chk("ib_end", i_axi_r_valid, 0);

    // Simultaneous requests: dBus first, then iBus burst 0x20 len 1
    i_axi_ar_valid = 1; i_axi_ar_payload_addr = 32'h20; i_axi_ar_payload_len = 8'd1;
    dreq(0, 30'h4, 0, 4'hF);
    #1;
    chk("arb_ar_blocked", i_axi_ar_ready, 0);
    tk;
    chk("arb_ar_blocked2", i_axi_ar_ready, 0);
    tk;
    chk("arb_d_ack", d_wb_ack, 1);
    chk("arb_d_data", d_wb_dat_miso, 32'hDEAD_BEEF);
    chk("arb_ar_blocked3", i_axi_ar_ready, 0);
    ddrop;
    tk;
    chk("arb_ar_ready", i_axi_ar_ready, 1);
    tk;
    i_axi_ar_valid = 0;
    tk;
    chk("arb_b0_valid", i_axi_r_valid, 1);
    chk("arb_b0_data", i_axi_r_payload_data, mem_val(8));
    chk("arb_b0_last", i_axi_r_payload_last, 0);
    tk;
    chk("arb_b1_valid", i_axi_r_valid, 1);
    chk("arb_b1_data", i_axi_r_payload_data, mem_val(9));
    chk("arb_b1_last", i_axi_r_payload_last, 1);
    tk;
    chk("arb_end", i_axi_r_valid, 0);

    // Unmapped read 0xC000_0000
    dreq(0, 30'h3000_0000, 0, 4'hF);
    tk;
    chk("um_ack", d_wb_ack, 1);
    chk("um_data", d_wb_dat_miso, 0);
    chk("um_cyc", wb_cyc, 0);
    chk("um_req", req_valid, 0);
    chk("um_ram_we", ram_we, 0);
    ddrop;
    tk;
    chk("um_ack_pulse", d_wb_ack, 0);

    // Peripheral slave index 15 >= WB_N
    dreq(0, 30'h23C0_0000, 0, 4'hF);
    tk;
    chk("ns_ack", d_wb_ack, 1);
    chk("ns_cyc", wb_cyc, 0);
    chk("ns_data", d_wb_dat_miso, 0);
    ddrop;
    tk;

    // BRAM write word 5
    dreq(1, 30'h5, 32'h1122_3344, 4'b1010);
    tk;
    chk("bw_we", ram_we, 1);
    chk("bw_addr", ram_addr, 5);
    chk("bw_wmsk", ram_wmsk, 4'b1010);
    chk("bw_wdata", ram_wdata, 32'h1122_3344);
    chk("bw_ack", d_wb_ack, 1);
    ddrop;
    tk;
    chk("bw_we_pulse", ram_we, 0);
    chk("bw_ack_pulse", d_wb_ack, 0);

    // Reset mid-transaction to slave 3
    dreq(0, 30'h20C0_0000, 0, 4'hF);
    tk;
    chk("mr_cyc", wb_cyc, 4'b1000);
    rst = 1'b1;
    #1;
    chk("mr_cyc_abort", wb_cyc, 0);
    chk("mr_ack", d_wb_ack, 0);
    ddrop;
    #1;
    rst = 1'b0;
    tk;
    chk("mr_idle", wb_cyc, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
